// File: rtl/nand_target_model.sv
// NAND flash target model: decodes the controller's pin cycles, holds a small page array and
// drives ready/busy and read data. Define NAND_STATUS_CMD_EN to enable the 70h status read.
module nand_target_model #(
    parameter int PAGE_BYTES = 16,
    parameter int PAGES      = 4,
    parameter int T_R_CYC    = 32,
    parameter int T_PROG_CYC = 64,
    parameter int T_ERAS_CYC = 96,
    parameter int T_RST_CYC  = 8
) (
    input  logic       P_clk,
    input  logic       P_nrst,
    input  logic       F_nCE,
    input  logic       F_CLE,
    input  logic       F_ALE,
    input  logic       F_nWE,
    input  logic       F_nRE,
    input  logic       F_nWP,
    input  logic [7:0] F_DIO_i,
    output logic [7:0] F_DIO_o,
    output logic       F_DIO_oe,
    output logic       F_nRB,
    output logic [2:0] T_State
);
    localparam int CB  = $clog2(PAGE_BYTES);
    localparam int RB  = $clog2(PAGES);
    localparam int TM1 = (T_R_CYC > T_PROG_CYC) ? T_R_CYC : T_PROG_CYC;
    localparam int TM2 = (TM1 > T_ERAS_CYC) ? TM1 : T_ERAS_CYC;
    localparam int TM3 = (TM2 > T_RST_CYC) ? TM2 : T_RST_CYC;
    localparam int CW  = $clog2(TM3);
    localparam logic [CW-1:0] LEN_R = CW'(T_R_CYC - 1);
    localparam logic [CW-1:0] LEN_P = CW'(T_PROG_CYC - 1);
    localparam logic [CW-1:0] LEN_E = CW'(T_ERAS_CYC - 1);
    localparam logic [CW-1:0] LEN_X = CW'(T_RST_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_ADDR = 3'd1, S_DIN = 3'd2, S_BUSY = 3'd3, S_DOUT = 3'd4, S_STAT = 3'd5
    } state_t;
    typedef enum logic [1:0] {OP_NONE, OP_READ, OP_PROG, OP_ERAS} op_t;

    state_t st_q, st_d, ret_q;
    op_t    op_q, go_op;
    logic   we_s1, we_s2, re_s1, re_s2, wp_s1, wp_s2;
    logic   cle_s, ale_s, nce_s;
    logic [7:0] dio_s, cmd_q;
    logic [2:0] acnt_q, need;
    logic [CB-1:0] col_q, idx_lo;
    logic [RB-1:0] row_q;
    logic [CB:0]   idx_q;
    logic [CW-1:0] cnt_q, go_len;
    logic busy_q, fail_q, go, ld_cmd, fail_wr, fail_val;
    logic [PAGE_BYTES-1:0][7:0]            buf_q;
    logic [PAGES-1:0][PAGE_BYTES-1:0][7:0] mem_q;

    // Control pins and DIO are sampled alongside the first nWE sync stage so they line up with the edge.
    wire we_rise = we_s1 & ~we_s2;
    wire re_fall = ~re_s1 & re_s2;
    wire re_rise = re_s1 & ~re_s2;
    wire cmd_ev  = we_rise & ~nce_s &  cle_s & ~ale_s;
    wire addr_ev = we_rise & ~nce_s & ~cle_s &  ale_s;
    wire data_ev = we_rise & ~nce_s & ~cle_s & ~ale_s;
    wire [7:0] status = {wp_s2, ~busy_q, 5'b0, fail_q};

    assign need    = (cmd_q == 8'h60) ? 3'd3 : 3'd5;
    assign idx_lo  = idx_q[CB-1:0];
    assign F_nRB   = ~busy_q;
    assign T_State = st_q;

    always_comb begin
        st_d = st_q; go = 1'b0; go_op = OP_NONE; go_len = '0;
        ld_cmd = 1'b0; fail_wr = 1'b0; fail_val = 1'b0;
        if (cmd_ev && dio_s == 8'hFF) begin
            st_d = S_BUSY; go = 1'b1; go_len = LEN_X; fail_wr = 1'b1;
        end
`ifdef NAND_STATUS_CMD_EN
        else if (cmd_ev && dio_s == 8'h70) begin
            st_d = S_STAT;
        end
`endif
        else if (busy_q) begin
            if (cmd_ev && st_q == S_STAT)
                st_d = S_BUSY;
            else if (cnt_q == '0 && st_q == S_BUSY)
                st_d = ret_q;
        end else if (cmd_ev) begin
            st_d = S_IDLE;
            case (st_q)
                S_ADDR: begin
                    if (cmd_q == 8'h00 && acnt_q == 3'd5 && dio_s == 8'h30) begin
                        st_d = S_BUSY; go = 1'b1; go_op = OP_READ; go_len = LEN_R;
                    end else if (cmd_q == 8'h60 && acnt_q == 3'd3 && dio_s == 8'hD0) begin
                        st_d = S_BUSY; go = 1'b1; go_len = LEN_E;
                        go_op = wp_s2 ? OP_ERAS : OP_NONE;
                        fail_wr = 1'b1; fail_val = ~wp_s2;
                    end
                end
                S_DIN: begin
                    if (dio_s == 8'h10) begin
                        st_d = S_BUSY; go = 1'b1; go_len = LEN_P;
                        go_op = wp_s2 ? OP_PROG : OP_NONE;
                        fail_wr = 1'b1; fail_val = ~wp_s2;
                    end
                end
                default: begin
                    if (dio_s == 8'h00 || dio_s == 8'h80 || dio_s == 8'h60) begin
                        st_d = S_ADDR; ld_cmd = 1'b1;
                    end
                end
            endcase
        end else if (addr_ev && st_q == S_ADDR && cmd_q == 8'h80 && acnt_q == 3'd4) begin
            st_d = S_DIN;
        end
    end

    always_ff @(posedge P_clk) begin
        if (!P_nrst) begin
            st_q <= S_IDLE; ret_q <= S_IDLE; op_q <= OP_NONE;
            we_s1 <= 1'b1; we_s2 <= 1'b1; re_s1 <= 1'b1; re_s2 <= 1'b1;
            wp_s1 <= 1'b0; wp_s2 <= 1'b0;
            cle_s <= 1'b0; ale_s <= 1'b0; nce_s <= 1'b1; dio_s <= '0;
            cmd_q <= '0; acnt_q <= '0; col_q <= '0; row_q <= '0; idx_q <= '0; cnt_q <= '0;
            busy_q <= 1'b0; fail_q <= 1'b0;
            F_DIO_o <= '0; F_DIO_oe <= 1'b0;
            buf_q <= '1; mem_q <= '1;
        end else begin
            we_s1 <= F_nWE; we_s2 <= we_s1;
            re_s1 <= F_nRE; re_s2 <= re_s1;
            wp_s1 <= F_nWP; wp_s2 <= wp_s1;
            cle_s <= F_CLE; ale_s <= F_ALE; nce_s <= F_nCE; dio_s <= F_DIO_i;
            st_q  <= st_d;

            if (ld_cmd) begin
                cmd_q <= dio_s; acnt_q <= '0;
                if (dio_s == 8'h80) buf_q <= '1;
            end
            if (cmd_ev && dio_s == 8'hFF) acnt_q <= '0;
            if (addr_ev && !busy_q && st_q == S_ADDR && acnt_q != need) begin
                acnt_q <= acnt_q + 3'd1;
                if (cmd_q == 8'h60) begin
                    if (acnt_q == 3'd0) row_q <= dio_s[RB-1:0];
                end else begin
                    if (acnt_q == 3'd0) col_q <= dio_s[CB-1:0];
                    if (acnt_q == 3'd2) row_q <= dio_s[RB-1:0];
                end
            end
            if (data_ev && st_q == S_DIN) begin
                buf_q[col_q] <= dio_s;
                col_q <= col_q + 1'b1;
            end
            if (fail_wr) fail_q <= fail_val;

            // Page operations move one byte per busy cycle; an abort simply stops the walk.
            if (go) begin
                busy_q <= 1'b1; cnt_q <= go_len; idx_q <= '0; op_q <= go_op;
                ret_q  <= (go_op == OP_READ) ? S_DOUT : S_IDLE;
            end else if (busy_q) begin
                if (cnt_q == '0) busy_q <= 1'b0;
                else             cnt_q  <= cnt_q - 1'b1;
                if (!idx_q[CB]) begin
                    idx_q <= idx_q + 1'b1;
                    case (op_q)
                        OP_READ: buf_q[idx_lo]        <= mem_q[row_q][idx_lo];
                        OP_PROG: mem_q[row_q][idx_lo] <= mem_q[row_q][idx_lo] & buf_q[idx_lo];
                        OP_ERAS: mem_q[row_q][idx_lo] <= 8'hFF;
                        default: ;
                    endcase
                end
            end

            if (we_rise) begin
                F_DIO_oe <= 1'b0;
            end else if (re_fall && !nce_s) begin
                if (st_q == S_DOUT) begin
                    F_DIO_o <= buf_q[col_q]; F_DIO_oe <= 1'b1;
                end else if (st_q == S_STAT) begin
                    F_DIO_o <= status; F_DIO_oe <= 1'b1;
                end
            end else if (re_rise) begin
                F_DIO_oe <= 1'b0;
                if (st_q == S_DOUT) col_q <= col_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_nand_target_model.sv
// Directed bench for nand_target_model: pin-level command/address/data cycles with hand-computed results.
module tb_nand_target_model;
    logic       P_clk = 1'b0;
    logic       P_nrst, F_nCE, F_CLE, F_ALE, F_nWE, F_nRE, F_nWP;
    logic [7:0] F_DIO_i, F_DIO_o;
    logic       F_DIO_oe, F_nRB;
    logic [2:0] T_State;
    int n_cmp = 0, n_err = 0, busy_tot = 0;

    always #5 P_clk = ~P_clk;

    nand_target_model dut (
        .P_clk(P_clk), .P_nrst(P_nrst), .F_nCE(F_nCE), .F_CLE(F_CLE), .F_ALE(F_ALE),
        .F_nWE(F_nWE), .F_nRE(F_nRE), .F_nWP(F_nWP), .F_DIO_i(F_DIO_i),
        .F_DIO_o(F_DIO_o), .F_DIO_oe(F_DIO_oe), .F_nRB(F_nRB), .T_State(T_State)
    );

    // Total busy cycles seen, sampled mid-cycle.
    always @(negedge P_clk) if (F_nRB === 1'b0) busy_tot++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic cle, input logic ale, input logic [7:0] d);
        @(negedge P_clk); F_CLE = cle; F_ALE = ale; F_DIO_i = d; F_nWE = 1'b0;
        repeat (3) @(negedge P_clk); F_nWE = 1'b1;
        repeat (3) @(negedge P_clk); F_CLE = 1'b0; F_ALE = 1'b0;
    endtask

    task automatic addr5(input logic [7:0] col, input logic [7:0] row);
        wr(0, 1, col); wr(0, 1, 8'h00); wr(0, 1, row); wr(0, 1, 8'h00); wr(0, 1, 8'h00);
    endtask

    task automatic wait_rdy(input string tag);
        int n = 0;
        while (!F_nRB && n < 2000) begin @(negedge P_clk); n++; end
        chk({tag, "_ready"}, F_nRB, 1);
    endtask

    task automatic rd_byte(output logic [7:0] d, output logic oe);
        @(negedge P_clk); F_nRE = 1'b0;
        repeat (3) @(negedge P_clk); d = F_DIO_o; oe = F_DIO_oe;
        F_nRE = 1'b1;
        repeat (3) @(negedge P_clk);
    endtask

    task automatic start_read(input logic [7:0] col, input logic [7:0] row);
        int b0;
        b0 = busy_tot;
        wr(1, 0, 8'h00); addr5(col, row); wr(1, 0, 8'h30);
        wait_rdy("rd");
        chk("rd_busy", busy_tot - b0, 32);
        chk("rd_state", T_State, 4);
    endtask

    initial begin
        logic [7:0] d, exp [16];
        logic oe;
        int b0, n;
        P_nrst = 1'b0; F_nCE = 1'b0; F_CLE = 1'b0; F_ALE = 1'b0;
        F_nWE = 1'b1; F_nRE = 1'b1; F_nWP = 1'b1; F_DIO_i = '0;
        repeat (3) @(negedge P_clk);
        P_nrst = 1'b1;
        chk("rst_nRB", F_nRB, 1); chk("rst_oe", F_DIO_oe, 0);
        chk("rst_state", T_State, 0); chk("rst_dout", F_DIO_o, 0);

        // fresh array reads all FF
        start_read(8'd0, 8'd0);
        for (int i = 0; i < 16; i++) begin
            rd_byte(d, oe);
            chk($sformatf("fresh_b%0d", i), d, 8'hFF);
            if (i == 0) chk("fresh_oe", oe, 1);
        end
        chk("oe_off", F_DIO_oe, 0);

        // program row1 col2 with A5,3C
        wr(1, 0, 8'h80); addr5(8'd2, 8'd1); chk("din_state", T_State, 2);
        wr(0, 0, 8'hA5); wr(0, 0, 8'h3C);
        b0 = busy_tot; wr(1, 0, 8'h10); wait_rdy("pg");
        chk("pg_busy", busy_tot - b0, 64); chk("pg_idle", T_State, 0);
        for (int i = 0; i < 16; i++) exp[i] = 8'hFF;
        exp[2] = 8'hA5; exp[3] = 8'h3C;
        start_read(8'd0, 8'd1);
        for (int i = 0; i < 16; i++) begin
            rd_byte(d, oe);
            chk($sformatf("pg_b%0d", i), d, exp[i]);
        end

        // re-program ANDs bits: A5 & 0F = 05
        wr(1, 0, 8'h80); addr5(8'd2, 8'd1); wr(0, 0, 8'h0F);
        wr(1, 0, 8'h10); wait_rdy("pg2");
        start_read(8'd2, 8'd1);
        rd_byte(d, oe); chk("and_b2", d, 8'h05);
        rd_byte(d, oe); chk("and_b3", d, 8'h3C);

        // column wrap on write and read: row3 col15 then col0
        wr(1, 0, 8'h80); addr5(8'd15, 8'd3); wr(0, 0, 8'h12); wr(0, 0, 8'h34);
        wr(1, 0, 8'h10); wait_rdy("pg3");
        start_read(8'd15, 8'd3);
        rd_byte(d, oe); chk("wrap_b15", d, 8'h12);
        rd_byte(d, oe); chk("wrap_b0", d, 8'h34);
        rd_byte(d, oe); chk("wrap_b1", d, 8'hFF);

        // erase row1
        wr(1, 0, 8'h60); wr(0, 1, 8'd1); wr(0, 1, 8'd0); wr(0, 1, 8'd0);
        b0 = busy_tot; wr(1, 0, 8'hD0); wait_rdy("er");
        chk("er_busy", busy_tot - b0, 96);
        start_read(8'd2, 8'd1);
        rd_byte(d, oe); chk("er_b2", d, 8'hFF);
        rd_byte(d, oe); chk("er_b3", d, 8'hFF);

        // write protect: busy still taken, array unchanged
        F_nWP = 1'b0; repeat (4) @(negedge P_clk);
        wr(1, 0, 8'h80); addr5(8'd0, 8'd2); wr(0, 0, 8'h00);
        b0 = busy_tot; wr(1, 0, 8'h10); wait_rdy("wp");
        chk("wp_busy", busy_tot - b0, 64);
`ifdef NAND_STATUS_CMD_EN
        wr(1, 0, 8'h70); chk("stat_state", T_State, 5);
        rd_byte(d, oe); chk("stat_byte", d, 8'h41);
`else
        wr(1, 0, 8'h70); chk("no_stat", T_State, 0);
`endif
        start_read(8'd0, 8'd2);
        rd_byte(d, oe); chk("wp_b0", d, 8'hFF);
        F_nWP = 1'b1; repeat (4) @(negedge P_clk);

        // abort erase: FF gives 8 busy cycles; the write task returns one cycle into them
        wr(1, 0, 8'h60); wr(0, 1, 8'd0); wr(0, 1, 8'd0); wr(0, 1, 8'd0); wr(1, 0, 8'hD0);
        repeat (10) @(negedge P_clk);
        chk("abort_busy_pre", F_nRB, 0);
        wr(1, 0, 8'hFF);
        n = 0;
        while (!F_nRB && n < 200) begin @(negedge P_clk); n++; end
        chk("abort_rest", n, 7); chk("abort_idle", T_State, 0);

        // wrong confirm after 80: back to IDLE, no array change
        wr(1, 0, 8'h80); addr5(8'd0, 8'd1); wr(0, 0, 8'h11);
        wr(1, 0, 8'h00); chk("wrong_cfm", T_State, 0);
        start_read(8'd0, 8'd1);
        rd_byte(d, oe); chk("wrong_b0", d, 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
